// File: rtl/rns_ex_sequencer.sv
// rns_ex_sequencer: time-shares one 8-bit modular adder across NUM_DOMAINS RNS residue channels, one domain per cycle.
// Optional macro RNS_RANGE_CHECK_EN adds per-domain operand range flags captured at accept.
module rns_ex_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter logic [NUM_DOMAINS*8-1:0] MODULI = {8'd251, 8'd253, 8'd255}
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               op_sel_i,
  input  logic [NUM_DOMAINS*8-1:0] op1_i,
  input  logic [NUM_DOMAINS*8-1:0] op2_i,
  input  logic [2:0]               res_addr_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [NUM_DOMAINS*8-1:0] result_o,
  output logic [2:0]               rsp_addr_o,
  output logic [NUM_DOMAINS-1:0]   range_err_o
);
  localparam int IW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DOMAINS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DOMAINS*8-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [1:0] op_q, op_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] a, b, m, r;
  logic [8:0] s;
  logic accept;
  assign accept = state_q == IDLE && req_valid_i && !flush_i;
  assign req_ready_o = state_q == IDLE && !flush_i;
  assign stall_o = state_q != IDLE;
  assign rsp_valid_o = state_q == DONE;
  assign result_o = res_q;
  assign rsp_addr_o = addr_q;
  always_comb begin
    a = '0;
    b = '0;
    m = '0;
    for (int k = 0; k < NUM_DOMAINS; k++)
      if (k == int'(idx_q)) begin
        a = op1_q[(NUM_DOMAINS-1-k)*8 +: 8];
        b = op2_q[(NUM_DOMAINS-1-k)*8 +: 8];
        m = MODULI[(NUM_DOMAINS-1-k)*8 +: 8];
      end
    s = op_q == 2'b00 ? {1'b0, a} + {1'b0, b} :
        op_q == 2'b01 ? {1'b0, a} + (b == 8'd0 ? 9'd0 : {1'b0, m} - {1'b0, b}) :
        op_q == 2'b10 ? {a, 1'b0} : {1'b0, a};
    r = s >= {1'b0, m} ? 8'(s - {1'b0, m}) : s[7:0];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    op1_d = op1_q;
    op2_d = op2_q;
    op_d = op_q;
    addr_d = addr_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        idx_d = '0;
        op1_d = op1_i;
        op2_d = op2_i;
        op_d = op_sel_i;
        addr_d = res_addr_i;
        res_d = '0;
      end
      RUN: if (flush_i) begin
        state_d = IDLE;
        idx_d = '0;
      end else begin
        for (int k = 0; k < NUM_DOMAINS; k++)
          if (k == int'(idx_q)) res_d[(NUM_DOMAINS-1-k)*8 +: 8] = r;
        state_d = idx_q == LAST ? DONE : RUN;
        idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
      end
      DONE: state_d = flush_i || rsp_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      op_q <= '0;
      addr_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      op_q <= op_d;
      addr_q <= addr_d;
      res_q <= res_d;
    end
  end
`ifdef RNS_RANGE_CHECK_EN
  logic [NUM_DOMAINS-1:0] rerr_q, rerr_d;
  // Flag bits follow the operand packing: domain 0 lands in the MSB.
  always_comb begin
    rerr_d = rerr_q;
    if (accept)
      for (int k = 0; k < NUM_DOMAINS; k++)
        rerr_d[NUM_DOMAINS-1-k] = (op1_i[(NUM_DOMAINS-1-k)*8 +: 8] >= MODULI[(NUM_DOMAINS-1-k)*8 +: 8]) |
          (op2_i[(NUM_DOMAINS-1-k)*8 +: 8] >= MODULI[(NUM_DOMAINS-1-k)*8 +: 8] && op_sel_i != 2'b11);
    else if (state_q != IDLE && flush_i)
      rerr_d = '0;
  end
  always_ff @(posedge clk_i) rerr_q <= reset_i ? '0 : rerr_d;
  assign range_err_o = rerr_q;
`else
  assign range_err_o = '0;
`endif
endmodule

// File: tb/tb_rns_ex_sequencer.sv
// tb_rns_ex_sequencer: scoreboard bench for rns_ex_sequencer with directed vectors and randomized ops.
module tb_rns_ex_sequencer;
  logic clk = 0, reset = 1, req_valid = 0, flush = 0, rsp_ready = 0;
  logic [1:0] op_sel = 0;
  logic [23:0] op1 = 0, op2 = 0;
  logic [2:0] res_addr = 0;
  logic req_ready, stall, rsp_valid;
  logic [23:0] result;
  logic [2:0] rsp_addr, range_err;
  typedef struct packed {logic [23:0] res; logic [2:0] addr; logic [2:0] rerr;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, rdy_mode = 1;
  int mods[3] = '{251, 253, 255};

  rns_ex_sequencer dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_sel_i(op_sel), .op1_i(op1), .op2_i(op2), .res_addr_i(res_addr), .flush_i(flush),
    .stall_o(stall), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .result_o(result),
    .rsp_addr_o(rsp_addr), .range_err_o(range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rsp_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
  end

  function automatic logic [23:0] model(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
    logic [23:0] out = 0;
    for (int k = 0; k < 3; k++) begin
      int av = int'(a[(2-k)*8 +: 8]);
      int bv = int'(b[(2-k)*8 +: 8]);
      int x = op == 0 ? (av + bv) % mods[k] : op == 1 ? (av - bv + mods[k]) % mods[k] :
              op == 2 ? (2 * av) % mods[k] : av;
      out[(2-k)*8 +: 8] = 8'(x);
    end
    return out;
  endfunction

  function automatic logic [2:0] rerr_model(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
    logic [2:0] e = 0;
`ifdef RNS_RANGE_CHECK_EN
    for (int k = 0; k < 3; k++)
      e[2-k] = int'(a[(2-k)*8 +: 8]) >= mods[k] || (int'(b[(2-k)*8 +: 8]) >= mods[k] && op != 3);
`endif
    return e;
  endfunction

  function automatic logic [23:0] rand_ops();
    logic [23:0] v = 0;
    for (int k = 0; k < 3; k++) begin
      int p = int'($urandom_range(0, 3));
      v[(2-k)*8 +: 8] = p == 0 ? 8'd0 : p == 1 ? 8'(mods[k] - 1) : 8'($urandom_range(0, mods[k] - 1));
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got result %0h with no pending op", result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("rsp_addr", rsp_addr, e.addr);
        chk("range_err", range_err, e.rerr);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                      input logic [2:0] ad, input bit push);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid = 1;
    op_sel = op;
    op1 = a;
    op2 = b;
    res_addr = ad;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: req_ready stayed %0b", req_ready);
        break;
      end
    end
    @(posedge clk);
    if (push) q.push_back('{res: model(op, a, b), addr: ad, rerr: rerr_model(op, a, b)});
    #1 req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || stall) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 300, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rsp_addr"}, rsp_addr, 0);
    chk({tag, "_range_err"}, range_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a, b;
    logic [1:0] op;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // ADD vector with cycle-accurate latency: RUN for 3 cycles, DONE after the 3rd edge past accept
    a = {8'd250, 8'd100, 8'd7};
    b = {8'd3, 8'd200, 8'd254};
    @(posedge clk);
    #1 req_valid = 1;
    op_sel = 2'b00;
    op1 = a;
    op2 = b;
    res_addr = 3'd5;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    @(posedge clk);
    q.push_back('{res: model(2'b00, a, b), addr: 3'd5, rerr: rerr_model(2'b00, a, b)});
    chk("add_vector_model", model(2'b00, a, b), {8'd2, 8'd47, 8'd6});
    #1 req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_stall", stall, 1);
      chk("run_no_rsp", rsp_valid, 0);
      chk("run_req_ready", req_ready, 0);
    end
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_stall", stall, 1);
    wait_idle();

    send(2'b01, {8'd5, 8'd0, 8'd10}, {8'd7, 8'd0, 8'd10}, 3'd1, 1);
    send(2'b10, {8'd200, 8'd126, 8'd128}, 24'h0, 3'd2, 1);
    send(2'b11, {8'd250, 8'd252, 8'd254}, {8'd9, 8'd9, 8'd9}, 3'd3, 1);
    wait_idle();

    // Backpressure: DONE held for 3 cycles with a competing request pending
    rdy_mode = 0;
    @(posedge clk);
    a = rand_ops();
    b = rand_ops();
    send(2'b00, a, b, 3'd6, 1);
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    chk("bp_reach_done", rsp_valid, 1);
    @(posedge clk);
    #1 req_valid = 1;
    op_sel = 2'b01;
    op1 = b;
    op2 = a;
    res_addr = 3'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_result", result, model(2'b00, a, b));
      chk("bp_req_ready", req_ready, 0);
    end
    rdy_mode = 1;
    send(2'b01, b, a, 3'd7, 1);
    wait_idle();

    // Flush during the second RUN cycle discards the op
    send(2'b00, rand_ops(), rand_ops(), 3'd4, 0);
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_rsp", rsp_valid, 0);
      chk("flush_idle", stall, 0);
    end
    send(2'b10, {8'd130, 8'd1, 8'd254}, 24'h0, 3'd4, 1);
    wait_idle();

    // Reset in RUN, then a back-to-back request
    send(2'b00, rand_ops(), rand_ops(), 3'd7, 0);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk_reset_outputs("run_reset");
    send(2'b01, {8'd0, 8'd252, 8'd1}, {8'd250, 8'd1, 8'd254}, 3'd2, 1);
    wait_idle();

    // Out-of-range D0 operand
    send(2'b00, {8'd252, 8'd10, 8'd20}, {8'd0, 8'd5, 8'd5}, 3'd3, 1);
    wait_idle();

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      send(op, rand_ops(), rand_ops(), 3'($urandom_range(0, 7)), 1);
    end
    wait_idle();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
